imem_boot_loader: RTL and testbench

Byte-stream boot loader that sits directly upstream of the instruction memory. It frames an incoming byte stream using start, end and escape bytes. It assembles data bytes into 32-bit instruction words, most-significant byte first, and drives a single-word write port into the instruction memory. It reports load progress, completion and overflow to the boot controller.

---
 rtl/imem_boot_loader.sv | 190 +++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Byte-stream boot loader that sits in front of the instruction memory.
// Incoming bytes are framed by START_BYTE and END_BYTE. ESC_BYTE makes the
// byte after it literal data. Data bytes are packed MSB-first into 32-bit words,
// and each word goes out on a single-word write port. If the frame ends on a
// partial word, that word is zero-padded and written in a one-cycle FLUSH
// state.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   byte_i        incoming stream byte
//   byte_valid_i  byte_i valid this cycle
//   byte_ready_o  loader accepts byte_i this cycle (low only in FLUSH)
//   wr_en_o       one-cycle word write strobe
//   wr_addr_o     word address of the write (saturates at DEPTH-1)
//   wr_data_o     word to write
//   loading_o     frame in progress (LOAD or FLUSH)
//   done_o        frame completed; held until the next START_BYTE
//   overflow_o    sticky: the frame carried more than DEPTH words
//   word_count_o  words written in the current or last frame
// -----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int          ADDR_W     = 6,
  parameter int          DEPTH      = 64,
  parameter logic [7:0]  START_BYTE = 8'hFE,
  parameter logic [7:0]  END_BYTE   = 8'hFF,
  parameter logic [7:0]  ESC_BYTE   = 8'hFD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              loading_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_MAX   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [31:0]       asm_q, asm_d;
  logic [1:0]        idx_q, idx_d;
  logic              esc_q, esc_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;

  logic              accept;
  logic              is_data;
  logic              commit;
  logic [31:0]       commit_word;

  assign byte_ready_o = (state_q != S_FLUSH);
  assign accept       = byte_valid_i && byte_ready_o;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so that no path
    // leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    asm_d        = asm_q;
    idx_d        = idx_q;
    esc_d        = esc_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    overflow_d   = overflow_q;
    word_count_d = word_count_q;
    is_data      = 1'b0;
    commit       = 1'b0;
    commit_word  = asm_q;

    // The write strobed last cycle retires now. The address then advances,
    // but it sticks at the top word instead of wrapping.
    if (wr_en_q) begin
      word_count_d = word_count_q + 1'b1;
      if (wr_addr_q != ADDR_MAX) wr_addr_d = wr_addr_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        // This START clear comes after the retire above, so it wins if a
        // FLUSH write retires on the same edge.
        if (accept && byte_i == START_BYTE) begin
          state_d      = S_LOAD;
          wr_addr_d    = '0;
          word_count_d = '0;
          overflow_d   = 1'b0;
          idx_d        = 2'd0;
          esc_d        = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (esc_q) begin
            is_data = 1'b1;
            esc_d   = 1'b0;
          end else if (byte_i == END_BYTE) begin
            state_d = (idx_q != 2'd0) ? S_FLUSH : S_DONE;
          end else if (byte_i == ESC_BYTE) begin
            esc_d = 1'b1;
          end else begin
            is_data = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        // The unreceived low bytes are already zero, because the first byte
        // of each word clears the rest of the assembly register.
        state_d = S_DONE;
        commit  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (is_data) begin
      idx_d = idx_q + 1'b1;
      case (idx_q)
        2'd0: asm_d = {byte_i, 24'h0};
        2'd1: asm_d = {asm_q[31:24], byte_i, 16'h0};
        2'd2: asm_d = {asm_q[31:16], byte_i, 8'h0};
        default: begin
          asm_d       = {asm_q[31:8], byte_i};
          commit      = 1'b1;
          commit_word = {asm_q[31:8], byte_i};
        end
      endcase
    end

    // Once DEPTH words have been written, later words only flag overflow.
    if (commit) begin
      if (word_count_q == COUNT_FULL) begin
        overflow_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_data_d = commit_word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      asm_q        <= '0;
      idx_q        <= 2'd0;
      esc_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the values from before the edge.
      state_q      <= state_d;
      asm_q        <= asm_d;
      idx_q        <= idx_d;
      esc_q        <= esc_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign loading_o    = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign done_o       = (state_q == S_DONE);
  assign overflow_o   = overflow_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Directed testbench for imem_boot_loader. It drives framed byte streams and
// checks the write strobes and status outputs against hand-computed values.
// A negedge monitor records every write the DUT issues.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        wr_en_o;
  logic [5:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic        loading_o;
  logic        done_o;
  logic        overflow_o;
  logic [6:0]  word_count_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0]  log_addr[$];
  logic [31:0] log_data[$];

  imem_boot_loader dut (
    .clk          (clk),
    .reset        (reset),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .loading_o    (loading_o),
    .done_o       (done_o),
    .overflow_o   (overflow_o),
    .word_count_o (word_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe, sampled midway between rising edges.
  always @(negedge clk) begin
    if (wr_en_o === 1'b1) begin
      log_addr.push_back(wr_addr_o);
      log_data.push_back(wr_data_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte for one rising edge, then return 1 ns after that edge.
  task automatic send(input logic [7:0] b);
    byte_i       = b;
    byte_valid_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pause(input int n);
    byte_valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  initial begin
    reset        = 1'b0;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;
    #12;

    // ---- Reset values ----
    check("rst_ready",    32'(byte_ready_o), 32'd1);
    check("rst_wr_en",    32'(wr_en_o),      32'd0);
    check("rst_addr",     32'(wr_addr_o),    32'd0);
    check("rst_data",     wr_data_o,         32'd0);
    check("rst_loading",  32'(loading_o),    32'd0);
    check("rst_done",     32'(done_o),       32'd0);
    check("rst_overflow", 32'(overflow_o),   32'd0);
    check("rst_count",    32'(word_count_o), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    pause(1);

    // ---- Test 1: single word ----
    clear_log();
    send(8'hFE);
    check("t1_loading", 32'(loading_o), 32'd1);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    check("t1_wr_en", 32'(wr_en_o),   32'd1);
    check("t1_addr",  32'(wr_addr_o), 32'd0);
    check("t1_data",  wr_data_o,      32'h12345678);
    send(8'hFF);
    pause(2);
    check("t1_nwrites", 32'(log_addr.size()), 32'd1);
    check("t1_done",    32'(done_o),          32'd1);
    check("t1_loading_end", 32'(loading_o),   32'd0);
    check("t1_count",   32'(word_count_o),    32'd1);

    // ---- Test 2: two words, strobe timing and address advance ----
    clear_log();
    send(8'hFE);
    check("t2_done_clr", 32'(done_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      send(8'(i));
      if (i == 2) check("t2_no_early_wr", 32'(wr_en_o), 32'd0);
      if (i == 3) begin
        check("t2_w0_en",   32'(wr_en_o),   32'd1);
        check("t2_w0_addr", 32'(wr_addr_o), 32'd0);
        check("t2_w0_data", wr_data_o,      32'h00010203);
      end
      if (i == 4) begin
        check("t2_pulse_end", 32'(wr_en_o),      32'd0);
        check("t2_addr_inc",  32'(wr_addr_o),    32'd1);
        check("t2_count_inc", 32'(word_count_o), 32'd1);
      end
      if (i == 7) begin
        check("t2_w1_en",   32'(wr_en_o),   32'd1);
        check("t2_w1_addr", 32'(wr_addr_o), 32'd1);
        check("t2_w1_data", wr_data_o,      32'h04050607);
      end
    end
    send(8'hFF);
    pause(2);
    check("t2_nwrites", 32'(log_addr.size()), 32'd2);
    check("t2_count",   32'(word_count_o),    32'd2);
    check("t2_done",    32'(done_o),          32'd1);

    // ---- Test 3: partial word flushed with zero padding ----
    clear_log();
    send_list('{8'hFE, 8'hAA, 8'hBB, 8'hFF});
    check("t3_flush_ready",   32'(byte_ready_o), 32'd0);
    check("t3_flush_loading", 32'(loading_o),    32'd1);
    pause(1);
    check("t3_wr_en",  32'(wr_en_o),      32'd1);
    check("t3_addr",   32'(wr_addr_o),    32'd0);
    check("t3_data",   wr_data_o,         32'hAABB0000);
    check("t3_done",   32'(done_o),       32'd1);
    check("t3_ready",  32'(byte_ready_o), 32'd1);
    pause(1);
    check("t3_nwrites", 32'(log_addr.size()), 32'd1);
    check("t3_count",   32'(word_count_o),    32'd1);

    // ---- Test 4: escaped control bytes ----
    clear_log();
    send_list('{8'hFE, 8'hFD, 8'hFF, 8'hFD, 8'hFE, 8'hFD, 8'hFD, 8'h11, 8'hFF});
    pause(2);
    check("t4_nwrites", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() > 0) begin
      check("t4_addr", 32'(log_addr[0]), 32'd0);
      check("t4_data", log_data[0],      32'hFFFEFD11);
    end
    check("t4_count", 32'(word_count_o), 32'd1);

    // ---- Test 5: overflow past DEPTH words ----
    clear_log();
    send(8'hFE);
    for (int w = 0; w < 65; w++) begin
      send(8'h00); send(8'h00); send(8'h00); send(8'h13);
      if (w == 63) check("t5_no_ovf_at_64", 32'(overflow_o), 32'd0);
      if (w == 64) check("t5_no_wr_65",     32'(wr_en_o),    32'd0);
    end
    send(8'hFF);
    pause(2);
    check("t5_nwrites", 32'(log_addr.size()), 32'd64);
    if (log_addr.size() == 64) begin
      check("t5_last_addr", 32'(log_addr[63]), 32'd63);
      check("t5_last_data", log_data[63],      32'h00000013);
    end
    check("t5_overflow", 32'(overflow_o),   32'd1);
    check("t5_count",    32'(word_count_o), 32'd64);
    check("t5_done",     32'(done_o),       32'd1);
    check("t5_addr_sat", 32'(wr_addr_o),    32'd63);

    // ---- Test 6: reset mid-frame, then a fresh frame ----
    clear_log();
    send_list('{8'hFE, 8'h01, 8'h02});
    byte_valid_i = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("t6_rst_loading", 32'(loading_o),    32'd0);
    check("t6_rst_data",    wr_data_o,         32'd0);
    check("t6_rst_count",   32'(word_count_o), 32'd0);
    check("t6_rst_ready",   32'(byte_ready_o), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    pause(1);
    check("t6_no_write", 32'(log_addr.size()), 32'd0);
    send(8'h33);
    check("t6_ignored", 32'(loading_o), 32'd0);
    send_list('{8'hFE, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF});
    pause(2);
    check("t6_nwrites", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() > 0) begin
      check("t6_addr", 32'(log_addr[0]), 32'd0);
      check("t6_data", log_data[0],      32'h01020304);
    end
    check("t6_count", 32'(word_count_o), 32'd1);
    check("t6_done",  32'(done_o),       32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
